// File: rtl/warp_gpr_file_if.sv
// Bundles the read, write and clear signals of one warp register file.
//   master: drives read/write/clear requests and samples rdata/clr_busy/clr_done
//   slave : the register file itself
interface warp_gpr_file_if #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned NUM_REGS  = 64,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WARPS = 16
);
  localparam int unsigned REG_W  = $clog2(NUM_REGS);
  localparam int unsigned WARP_W = $clog2(NUM_WARPS);
  localparam int unsigned VEC_W  = NUM_LANES * DATA_W;

  logic [NUM_LANES-1:0] read_en_0;
  logic [NUM_LANES-1:0] read_en_1;
  logic [WARP_W-1:0]    rd_warp;
  logic [REG_W-1:0]     raddr_0;
  logic [REG_W-1:0]     raddr_1;
  logic [NUM_LANES-1:0] write_en;
  logic [WARP_W-1:0]    wr_warp;
  logic [REG_W-1:0]     waddr;
  logic [VEC_W-1:0]     wdata;
  logic [VEC_W-1:0]     rdata_0;
  logic [VEC_W-1:0]     rdata_1;
  logic                 clr_req;
  logic [WARP_W-1:0]    clr_warp;
  logic                 clr_busy;
  logic                 clr_done;

  modport master (
    output read_en_0, read_en_1, rd_warp, raddr_0, raddr_1,
    output write_en, wr_warp, waddr, wdata, clr_req, clr_warp,
    input  rdata_0, rdata_1, clr_busy, clr_done
  );

  modport slave (
    input  read_en_0, read_en_1, rd_warp, raddr_0, raddr_1,
    input  write_en, wr_warp, waddr, wdata, clr_req, clr_warp,
    output rdata_0, rdata_1, clr_busy, clr_done
  );
endinterface

// File: rtl/warp_gpr_file.sv
// Per-warp SIMT general-purpose register file.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : warp_gpr_file_if slave port
//                - two registered read ports with per-lane enables (shared rd_warp)
//                - one write port with per-lane enables (own wr_warp)
//                - write-to-read bypass, optional hard-zero register 0
//                - warp-clear engine (clr_req/clr_warp, clr_busy, clr_done)
module warp_gpr_file #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned NUM_REGS  = 64,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WARPS = 16,
  parameter int unsigned ZERO_REG  = 0
) (
  input  logic clk,
  input  logic rst_n,
  warp_gpr_file_if.slave bus
);
  localparam int unsigned REG_W  = $clog2(NUM_REGS);
  localparam int unsigned WARP_W = $clog2(NUM_WARPS);
  localparam int unsigned VEC_W  = NUM_LANES * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [REG_W-1:0]  cnt_q, cnt_d;
  logic [WARP_W-1:0] clr_warp_q, clr_warp_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic [VEC_W-1:0]  rdata_q [2];
  logic [VEC_W-1:0]  rdata_d [2];

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem [NUM_WARPS][NUM_REGS][NUM_LANES];

  // Effective write of this cycle: clear engine has priority over the external port.
  logic [NUM_LANES-1:0] we_c;
  logic [WARP_W-1:0]    we_warp_c;
  logic [REG_W-1:0]     we_addr_c;
  logic [VEC_W-1:0]     we_data_c;
  logic                 ext_ok_c;

  always_comb begin
    ext_ok_c  = (32'(bus.waddr) < NUM_REGS) && (32'(bus.wr_warp) < NUM_WARPS) &&
                !((ZERO_REG != 0) && (bus.waddr == '0));
    we_c      = '0;
    we_warp_c = bus.wr_warp;
    we_addr_c = bus.waddr;
    we_data_c = bus.wdata;
    if (state_q == ST_CLEAR) begin
      we_warp_c = clr_warp_q;
      we_addr_c = cnt_q;
      we_data_c = '0;
      if (32'(clr_warp_q) < NUM_WARPS) begin
        we_c = '1;
      end
    end else if (ext_ok_c) begin
      we_c = bus.write_en;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (we_c[l]) begin
        mem[we_warp_c][we_addr_c][l] <= we_data_c[l*DATA_W +: DATA_W];
      end
    end
  end

  // Read ports: disabled lanes hold, invalid/zero addresses load 0, matching writes bypass.
  logic [REG_W-1:0]     raddr_c [2];
  logic [NUM_LANES-1:0] ren_c   [2];
  logic                 rd_ok_c [2];
  logic                 hit_c   [2];

  always_comb begin
    raddr_c[0] = bus.raddr_0;
    raddr_c[1] = bus.raddr_1;
    ren_c[0]   = bus.read_en_0;
    ren_c[1]   = bus.read_en_1;
    for (int unsigned p = 0; p < 2; p++) begin
      rdata_d[p] = rdata_q[p];
      rd_ok_c[p] = (32'(bus.rd_warp) < NUM_WARPS) && (32'(raddr_c[p]) < NUM_REGS) &&
                   !((ZERO_REG != 0) && (raddr_c[p] == '0));
      hit_c[p]   = (we_warp_c == bus.rd_warp) && (we_addr_c == raddr_c[p]);
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (ren_c[p][l]) begin
          if (!rd_ok_c[p]) begin
            rdata_d[p][l*DATA_W +: DATA_W] = '0;
          end else if (hit_c[p] && we_c[l]) begin
            rdata_d[p][l*DATA_W +: DATA_W] = we_data_c[l*DATA_W +: DATA_W];
          end else begin
            rdata_d[p][l*DATA_W +: DATA_W] = mem[bus.rd_warp][raddr_c[p]][l];
          end
        end
      end
    end
  end

  // Warp-clear sequencer: one register row per cycle, then a one-cycle done pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_warp_d = clr_warp_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d    = ST_CLEAR;
          cnt_d      = '0;
          clr_warp_d = bus.clr_warp;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == REG_W'(NUM_REGS - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + REG_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    clr_busy_d = (state_d == ST_CLEAR);
    clr_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clr_warp_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_warp_q <= clr_warp_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign bus.rdata_0  = rdata_q[0];
  assign bus.rdata_1  = rdata_q[1];
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;

endmodule

// File: doc/warp_gpr_file.md
# warp_gpr_file

Parametrised per-warp general-purpose register file for the SIMT datapath. It holds NUM_WARPS × NUM_REGS × NUM_LANES words and serves two read ports and one write port, all with per-lane enables. It generalises the fixed 16-lane / 64-register / 32-bit register block in four ways:

- independent read and write warp selects;
- registered reads with write-to-read bypass;
- an optional hard-zero register 0;
- a hardware warp-clear engine, used at warp launch.

## Interface
Parameters:
- NUM_LANES, 16, lanes per warp
- NUM_REGS, 64, registers per lane per warp (≥2)
- DATA_W, 32, register width
- NUM_WARPS, 16, warp contexts (≥2)
- ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes
- Derived: REG_W = $clog2(NUM_REGS), WARP_W = $clog2(NUM_WARPS)

Ports:
- clk  in  1  clock; everything samples on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- read_en_0, read_en_1  in  NUM_LANES  per-lane read enable, ports 0/1
- rd_warp  in  WARP_W  warp selected for both read ports
- raddr_0, raddr_1  in  REG_W  read addresses
- write_en  in  NUM_LANES  per-lane write enable
- wr_warp  in  WARP_W  warp selected for the write
- waddr  in  REG_W  write address
- wdata  in  NUM_LANES*DATA_W  lane L occupies bits [L*DATA_W +: DATA_W]
- rdata_0, rdata_1  out  NUM_LANES*DATA_W  registered read data, same packing as wdata
- clr_req  in  1  request to zero every register of clr_warp
- clr_warp  in  WARP_W  warp to clear
- clr_busy  out  1  clear engine active; external writes are dropped while high
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- **Storage:** not reset; contents are undefined until written or cleared.
- **Write:** at each edge, for every lane L with write_en[L] set, mem[wr_warp][waddr][L] ← lane L of wdata.
  - The write is ignored if clr_busy=1, if waddr ≥ NUM_REGS, or if wr_warp ≥ NUM_WARPS.
  - If ZERO_REG=1 and waddr=0, the write is also ignored.
- **Read, per port p and lane L:**
  - If read_en_p[L] is set, rdata_p lane L is loaded at the edge with mem[rd_warp][raddr_p][L].
  - If read_en_p[L] is clear, rdata_p lane L holds its previous value.
  - Out-of-range addresses and, with ZERO_REG=1, raddr=0 load 0.
- **Bypass:** if the effective write (external or clear engine) in the same cycle targets the same warp, address and lane as an enabled read, the read loads the new write data, never the old contents. Both ports can bypass at once.
- **Clear FSM:** IDLE → CLEAR → DONE → IDLE.
  - IDLE: clr_req=1 latches clr_warp, sets cnt=0 and moves to CLEAR.
  - CLEAR: each cycle writes 0 to all lanes at (latched warp, cnt), then cnt increments. When cnt = NUM_REGS-1, the FSM moves to DONE after that write.
  - DONE: asserts clr_done for one cycle, then returns to IDLE.
  - clr_req is ignored outside IDLE.
  - Reads stay serviced during a clear. Reads of the warp being cleared see partially cleared contents, bypass included.
- **Outputs per state:** clr_busy=1 exactly in CLEAR; clr_done=1 exactly in DONE.
- **Reset (async, any time, including mid-clear):** FSM→IDLE, cnt=0, clr_busy=0, clr_done=0, rdata_0=rdata_1=0. A clear interrupted by reset is abandoned and storage keeps its partially cleared state.

## Timing
- **Write latency:** 1 edge. Data written at edge E is readable by a read sampled at edge E+1, and also at edge E itself through bypass.
- **Read latency:** raddr/read_en/rd_warp sampled at edge E; rdata is valid after E and stable until the next enabled read.
- **Clear, with clr_req sampled at edge E0:**
  - clr_busy is high after E0.
  - Register k is zeroed at edge E(k+1), for k = 0..NUM_REGS-1.
  - clr_done is high between E(NUM_REGS) and E(NUM_REGS+1); clr_busy is low in that window.
  - External writes are accepted again in the DONE cycle.
  - Total busy window: NUM_REGS cycles.
- **Simultaneous events:** a write and a clear request in the same IDLE cycle are both honoured; the write lands at E0, before the clear starts.
- **Throughput:** one read per port per cycle, one write per cycle, no stalls except clr_busy.

## Test plan
- **Per-warp isolation:** default parameters, all 16 warps × 64 registers. Write random data with write_en=16'hFFFF, then read the next cycle on port 0, then port 1, then both with rd_warp ≠ wr_warp patterns. rdata must equal the data written to the (rd_warp, raddr) pair, and other warps must be unaffected.
- **Lane masks and bypass:**
  - write_en=16'h00F0 to reg 5 with value 32'hA5A5_0000+L. Only lanes 4–7 change; rdata for the other lanes holds its previous value when read_en=0.
  - A same-cycle read of reg 5 on both ports returns the new values on lanes 4–7 (bypass).
- **Clear:**
  - Fill warp 3 with 32'hFFFF_FFFF, pulse clr_req with clr_warp=3. clr_busy stays high for exactly 64 cycles, clr_done pulses once, and every register of warp 3 then reads 0 while warp 2 is unchanged.
  - An external write during busy is dropped.
  - clr_req during busy is ignored.
- **Reset mid-clear:** assert rst_n=0 at cycle 20 of a clear. clr_busy and clr_done drop immediately and rdata reads 0. Registers 0..18 of the warp read 0; register 40 keeps its old value.
- **ZERO_REG=1, NUM_LANES=4, NUM_REGS=32, DATA_W=16:** writing 16'h1234 to reg 0 then reading it returns 0. Reg 31 round-trips 16'hBEEF.
- **Both-port conflict:** raddr_0=raddr_1=waddr=7 in the same cycle with write_en=all. Both ports return the new wdata after the edge.
